// File: rtl/tcp_checksum_insert_if.sv
// Stream bundle for the checksum inserter: frame input, checksum input, frame output.
interface tcp_checksum_insert_if;
  logic [511:0] S_AXIS_TDATA;
  logic [63:0]  S_AXIS_TKEEP;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;
  logic [15:0]  S_CSUM_TDATA;
  logic         S_CSUM_TVALID;
  logic         S_CSUM_TREADY;
  logic [511:0] M_AXIS_TDATA;
  logic [63:0]  M_AXIS_TKEEP;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY;

  // Inserter side
  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST,
    output S_AXIS_TREADY,
    input  S_CSUM_TDATA, S_CSUM_TVALID,
    output S_CSUM_TREADY,
    output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TVALID, M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  // Environment side (frame source, checksum engine, downstream sink)
  modport master (
    output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST,
    input  S_AXIS_TREADY,
    output S_CSUM_TDATA, S_CSUM_TVALID,
    input  S_CSUM_TREADY,
    input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TVALID, M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/tcp_checksum_insert.sv
// Buffers each frame until the engine's checksum arrives, then writes the
// checksum into the head beat and forwards the frame through a register slice.
module tcp_checksum_insert #(
  parameter int unsigned DATA_DEPTH  = 64,
  parameter int unsigned CSUM_DEPTH  = 8,
  parameter int unsigned CSUM_OFFSET = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tcp_checksum_insert_if.slave bus,
  output logic                 csum_err
);

  localparam int unsigned TDW    = 512;
  localparam int unsigned KW     = 64;
  localparam int unsigned BW     = TDW + KW + 1;
  localparam int unsigned DAW    = $clog2(DATA_DEPTH);
  localparam int unsigned CAW    = $clog2(CSUM_DEPTH);
  localparam int unsigned MSB_LO = 8 * CSUM_OFFSET;
  localparam int unsigned LSB_LO = 8 * (CSUM_OFFSET + 1);
  localparam logic [DAW:0] D_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [CAW:0] C_FULL = (CAW+1)'(CSUM_DEPTH);

  typedef enum logic [0:0] {ST_HEAD = 1'b0, ST_BODY = 1'b1} state_t;

  // Storage and pointers (extra MSB distinguishes full from empty)
  logic [BW-1:0] r_dmem [DATA_DEPTH];
  logic [15:0]   r_cmem [CSUM_DEPTH];
  logic [DAW:0]  r_dwr, r_drd;
  logic [CAW:0]  r_cwr, r_crd;
  logic [DAW:0]  r_pending;
  logic          r_csum_err;

  // Output slice
  state_t        r_state, w_state_nxt;
  logic [TDW-1:0] r_m_data;
  logic [KW-1:0]  r_m_keep;
  logic           r_m_valid;
  logic           r_m_last;

  logic [DAW:0]   w_dcnt;
  logic [CAW:0]   w_ccnt;
  logic           w_s_ready, w_c_ready;
  logic           w_d_push, w_tlast_acc, w_c_acc, w_orphan, w_c_push;
  logic           w_d_nempty, w_c_nempty, w_slice_free;
  logic [BW-1:0]  w_rd_beat;
  logic [TDW-1:0] w_rd_data;
  logic [KW-1:0]  w_rd_keep;
  logic           w_rd_last;
  logic [15:0]    w_c_head;
  logic           w_load, w_c_pop;
  logic [TDW-1:0] w_ld_data;

  assign w_dcnt    = r_dwr - r_drd;
  assign w_ccnt    = r_cwr - r_crd;
  assign w_s_ready = (w_dcnt < D_FULL);
  assign w_c_ready = (w_ccnt < C_FULL);

  assign w_d_push    = bus.S_AXIS_TVALID && w_s_ready;
  assign w_tlast_acc = w_d_push && bus.S_AXIS_TLAST;
  assign w_c_acc     = bus.S_CSUM_TVALID && w_c_ready;
  assign w_orphan    = w_c_acc && (r_pending == '0) && !w_tlast_acc;
  assign w_c_push    = w_c_acc && !w_orphan;

  assign w_d_nempty   = (w_dcnt != '0);
  assign w_c_nempty   = (w_ccnt != '0);
  assign w_slice_free = !r_m_valid || bus.M_AXIS_TREADY;

  assign w_rd_beat = r_dmem[r_drd[DAW-1:0]];
  assign w_rd_data = w_rd_beat[BW-1 -: TDW];
  assign w_rd_keep = w_rd_beat[KW:1];
  assign w_rd_last = w_rd_beat[0];
  assign w_c_head  = r_cmem[r_crd[CAW-1:0]];

  // Beat storage write (no reset needed on array contents)
  always_ff @(posedge clk) begin
    if (w_d_push) begin
      r_dmem[r_dwr[DAW-1:0]] <= {bus.S_AXIS_TDATA, bus.S_AXIS_TKEEP, bus.S_AXIS_TLAST};
    end
    if (w_c_push) begin
      r_cmem[r_cwr[CAW-1:0]] <= bus.S_CSUM_TDATA;
    end
  end

  // FIFO pointers, pending-frame counter and sticky orphan flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwr      <= '0;
      r_drd      <= '0;
      r_cwr      <= '0;
      r_crd      <= '0;
      r_pending  <= '0;
      r_csum_err <= 1'b0;
    end else begin
      if (w_d_push) r_dwr <= r_dwr + (DAW+1)'(1);
      if (w_load)   r_drd <= r_drd + (DAW+1)'(1);
      if (w_c_push) r_cwr <= r_cwr + (CAW+1)'(1);
      if (w_c_pop)  r_crd <= r_crd + (CAW+1)'(1);
      if (w_tlast_acc && !w_c_push) begin
        r_pending <= r_pending + (DAW+1)'(1);
      end else if (w_c_push && !w_tlast_acc) begin
        r_pending <= r_pending - (DAW+1)'(1);
      end
      if (w_orphan) r_csum_err <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_HEAD;
    else        r_state <= w_state_nxt;
  end

  // Next state: a loaded TLAST beat always ends the frame
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = w_rd_last ? ST_HEAD : ST_BODY;
    end
  end

  // Output decode: load conditions and checksum insertion on the head beat
  always_comb begin
    w_load    = 1'b0;
    w_c_pop   = 1'b0;
    w_ld_data = w_rd_data;
    case (r_state)
      ST_HEAD: begin
        w_ld_data[MSB_LO +: 8] = w_c_head[15:8];
        w_ld_data[LSB_LO +: 8] = w_c_head[7:0];
        if (w_d_nempty && w_c_nempty && w_slice_free) begin
          w_load  = 1'b1;
          w_c_pop = 1'b1;
        end
      end
      ST_BODY: begin
        if (w_d_nempty && w_slice_free) w_load = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register slice; payload holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_load) begin
      r_m_data  <= w_ld_data;
      r_m_keep  <= w_rd_keep;
      r_m_last  <= w_rd_last;
      r_m_valid <= 1'b1;
    end else if (bus.M_AXIS_TREADY) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.S_AXIS_TREADY = w_s_ready;
  assign bus.S_CSUM_TREADY = w_c_ready;
  assign bus.M_AXIS_TDATA  = r_m_data;
  assign bus.M_AXIS_TKEEP  = r_m_keep;
  assign bus.M_AXIS_TVALID = r_m_valid;
  assign bus.M_AXIS_TLAST  = r_m_last;
  assign csum_err          = r_csum_err;

endmodule

// File: tb/tb_tcp_checksum_insert.sv
// Scoreboard bench for tcp_checksum_insert: expected beats queued at stimulus,
// popped and compared by an independent output monitor.
module tb_tcp_checksum_insert;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  localparam logic [63:0] KFULL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic csum_err;

  tcp_checksum_insert_if bus();

  tcp_checksum_insert #(.DATA_DEPTH(64), .CSUM_DEPTH(8), .CSUM_OFFSET(50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .csum_err (csum_err)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_out = 0;

  // Byte i of beat = seed + i
  function automatic logic [511:0] pat(input logic [7:0] seed);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = seed + 8'(i);
    return v;
  endfunction

  // Checksum lands in bytes 50 (MSB) and 51 (LSB): bits 400..415
  function automatic logic [511:0] ins(input logic [511:0] d, input logic [15:0] c);
    logic [511:0] v;
    v = d;
    v[407:400] = c[15:8];
    v[415:408] = c[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Output monitor: compares every handshake against the scoreboard and checks stall stability
  bit    stalled = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t act, exp;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      act = '{d: bus.M_AXIS_TDATA, k: bus.M_AXIS_TKEEP, l: bus.M_AXIS_TLAST};
      if (stalled) begin
        n_cmp++;
        if (!bus.M_AXIS_TVALID || act !== held) begin
          n_bad++;
          $display("FAIL stall_hold: valid=%b data=%h, held data=%h", bus.M_AXIS_TVALID, act.d, held.d);
        end
      end
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat%0d: data=%h", n_out, act.d);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_bad++;
            $display("FAIL beat%0d: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                     n_out, act.d, act.k, act.l, exp.d, exp.k, exp.l);
          end
        end
        n_out++;
      end
      stalled = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      held    = act;
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit rdy;
    int cyc;
    bus.S_AXIS_TDATA  = d;
    bus.S_AXIS_TKEEP  = k;
    bus.S_AXIS_TLAST  = l;
    bus.S_AXIS_TVALID = 1'b1;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 300) begin
      @(negedge clk);
      rdy = bus.S_AXIS_TREADY;
      @(posedge clk);
      cyc++;
    end
    #1;
    bus.S_AXIS_TVALID = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept_timeout: got ready=0, want ready=1");
    end
  endtask

  task automatic send_csum(input logic [15:0] c);
    bit rdy;
    int cyc;
    bus.S_CSUM_TDATA  = c;
    bus.S_CSUM_TVALID = 1'b1;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 300) begin
      @(negedge clk);
      rdy = bus.S_CSUM_TREADY;
      @(posedge clk);
      cyc++;
    end
    #1;
    bus.S_CSUM_TVALID = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL csum_accept_timeout: got ready=0, want ready=1");
    end
  endtask

  // Queue the expected frame, then drive its beats back to back
  task automatic send_frame(input logic [7:0] seed, input int n, input logic [63:0] k,
                            input logic [15:0] c);
    logic [511:0] d;
    for (int b = 0; b < n; b++) begin
      d = pat(seed + 8'(b * 17));
      sb.push_back('{d: (b == 0) ? ins(d, c) : d, k: k, l: (b == n - 1)});
    end
    for (int b = 0; b < n; b++) begin
      send_beat(pat(seed + 8'(b * 17)), k, b == n - 1);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(bus.M_AXIS_TVALID), 64'd0);
    chk({tag, "_tdata"},  64'(bus.M_AXIS_TDATA != '0), 64'd0);
    chk({tag, "_tkeep"},  bus.M_AXIS_TKEEP, 64'd0);
    chk({tag, "_tlast"},  64'(bus.M_AXIS_TLAST), 64'd0);
    chk({tag, "_csum_err"}, 64'(csum_err), 64'd0);
    chk({tag, "_s_ready"}, 64'(bus.S_AXIS_TREADY), 64'd1);
    chk({tag, "_c_ready"}, 64'(bus.S_CSUM_TREADY), 64'd1);
  endtask

  initial begin
    bus.S_AXIS_TDATA  = '0;
    bus.S_AXIS_TKEEP  = '0;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.S_CSUM_TDATA  = '0;
    bus.S_CSUM_TVALID = 1'b0;
    bus.M_AXIS_TREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;

    // Single-beat frame, checksum one cycle after TLAST
    send_frame(8'h00, 1, KFULL, 16'hBEEF);
    send_csum(16'hBEEF);
    @(negedge clk);
    chk("t1_no_early_valid", 64'(bus.M_AXIS_TVALID), 64'd0);
    @(negedge clk);
    chk("t1_valid_after_csum", 64'(bus.M_AXIS_TVALID), 64'd1);
    chk("t1_byte50", 64'(bus.M_AXIS_TDATA[407:400]), 64'hBE);
    chk("t1_byte51", 64'(bus.M_AXIS_TDATA[415:408]), 64'hEF);
    wait_drain("t1_drain");

    // 3-beat frame, checksum delayed 10 cycles
    send_frame(8'h10, 3, KFULL, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_wait_valid", 64'(bus.M_AXIS_TVALID), 64'd0);
    end
    @(posedge clk); #1;
    send_csum(16'h1234);
    @(negedge clk);
    chk("t2_no_early_valid", 64'(bus.M_AXIS_TVALID), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_contiguous", 64'(bus.M_AXIS_TVALID), 64'd1);
    end
    wait_drain("t2_drain");

    // Back-to-back frames with downstream ready toggling; B uses partial TKEEP
    fork
      begin
        send_frame(8'h40, 2, KFULL, 16'h1111);
        send_frame(8'h80, 1, 64'h0000_0000_FFFF_FFFF, 16'h2222);
        send_csum(16'h1111);
        send_csum(16'h2222);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          bus.M_AXIS_TREADY = ~bus.M_AXIS_TREADY;
        end
        bus.M_AXIS_TREADY = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // Fill the data FIFO with a 64-beat frame while downstream is stalled
    bus.M_AXIS_TREADY = 1'b0;
    send_frame(8'hC0, 64, KFULL, 16'h5A5A);
    @(negedge clk);
    chk("t4_s_ready_full", 64'(bus.S_AXIS_TREADY), 64'd0);
    @(posedge clk); #1;
    bus.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_release", 64'(bus.M_AXIS_TVALID), 64'd0);
    end
    @(posedge clk); #1;
    send_csum(16'h5A5A);
    wait_drain("t4_drain");
    chk("t4_s_ready_after", 64'(bus.S_AXIS_TREADY), 64'd1);

    // Orphan checksum, then a normal frame
    chk("t5_err_before", 64'(csum_err), 64'd0);
    send_csum(16'hABCD);
    @(negedge clk);
    chk("t5_err_set", 64'(csum_err), 64'd1);
    chk("t5_nothing_out", 64'(bus.M_AXIS_TVALID), 64'd0);
    @(posedge clk); #1;
    send_frame(8'h33, 2, KFULL, 16'h3C3C);
    send_csum(16'h3C3C);
    wait_drain("t5_drain");
    chk("t5_err_sticky", 64'(csum_err), 64'd1);

    // Reset mid-frame discards the partial frame
    send_beat(pat(8'h70), KFULL, 1'b0);
    send_beat(pat(8'h81), KFULL, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t6_reset");
    @(posedge clk); #1;
    send_frame(8'h55, 1, KFULL, 16'h0F0F);
    send_csum(16'h0F0F);
    wait_drain("t6_drain");
    repeat (5) @(negedge clk);
    chk("final_no_extra_beats", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
